// File: rtl/route_check.sv
// rtl/route_check.sv - streaming tour validator: duplicate/range check per tour, saturating pass/fail counters
// Optional ROUTE_CHECK_FIXED_START_EN: require every tour to start at city 0 (reported through err_range).
module route_check #(
  parameter int CITY_NUM     = 64,
  parameter int CITY_NUM_LOG = 6,
  parameter int CITY_DIV     = CITY_NUM / 8,
  parameter int CITY_DIV_LOG = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      in_valid,
  input  logic [8*CITY_NUM_LOG-1:0] in_data,
  output logic                      done,
  output logic                      ok,
  output logic                      err_dup,
  output logic                      err_range,
  output logic [15:0]               pass_count,
  output logic [15:0]               fail_count
);

  localparam int W = 8 * CITY_NUM_LOG;
  localparam logic [CITY_NUM-1:0]     MASK_ONE = CITY_NUM'(1);
  localparam logic [CITY_DIV_LOG-1:0] LAST_IDX = CITY_DIV_LOG'(CITY_DIV - 1);

  // Stage 1: beat register and position within the tour
  logic [CITY_DIV_LOG-1:0] beat_cnt;
  logic                    s1_valid;
  logic                    s1_last;
  logic [CITY_DIV_LOG-1:0] s1_idx;
  logic [W-1:0]            s1_data;
  logic                    cnt_last;

  assign cnt_last = (beat_cnt == LAST_IDX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat_cnt <= '0;
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_idx   <= '0;
      s1_data  <= '0;
    end else if (clear) begin
      beat_cnt <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data  <= in_data;
        s1_idx   <= beat_cnt;
        s1_last  <= cnt_last;
        beat_cnt <= cnt_last ? '0 : beat_cnt + CITY_DIV_LOG'(1);
      end
    end
  end

  // Stage 2 combinational: one-hot masks, range and duplicate detection
  logic [CITY_NUM_LOG-1:0] lane [8];
  logic [CITY_NUM-1:0]     masks;
  logic [CITY_NUM-1:0]     bitmap;
  logic [CITY_NUM-1:0]     bitmap_base;
  logic                    first_beat;
  logic                    beat_dup;
  logic                    beat_range;

  assign first_beat  = (s1_idx == '0);
  // Treating the bitmap as empty on beat 0 lets tours run back-to-back.
  assign bitmap_base = first_beat ? '0 : bitmap;

  always_comb begin
    masks      = '0;
    beat_dup   = 1'b0;
    beat_range = 1'b0;
    for (int k = 0; k < 8; k++) begin
      lane[k] = s1_data[k*CITY_NUM_LOG +: CITY_NUM_LOG];
    end
    for (int k = 0; k < 8; k++) begin
      if (int'(lane[k]) < CITY_NUM) begin
        masks = masks | (MASK_ONE << lane[k]);
      end else begin
        beat_range = 1'b1;
      end
    end
    for (int i = 0; i < 7; i++) begin
      for (int j = i + 1; j < 8; j++) begin
        if (lane[i] == lane[j]) begin
          beat_dup = 1'b1;
        end
      end
    end
    if ((masks & bitmap_base) != '0) begin
      beat_dup = 1'b1;
    end
  end

`ifdef ROUTE_CHECK_FIXED_START_EN
  logic beat_start;
  logic start_flag;
  assign beat_start = first_beat && (lane[0] != '0);
`endif

  // Stage 2 registers: bitmap and sticky per-tour flags
  logic s2_valid;
  logic s2_last;
  logic dup_flag;
  logic range_flag;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bitmap     <= '0;
      s2_valid   <= 1'b0;
      s2_last    <= 1'b0;
      dup_flag   <= 1'b0;
      range_flag <= 1'b0;
    end else if (clear) begin
      s2_valid   <= 1'b0;
      dup_flag   <= 1'b0;
      range_flag <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_last    <= s1_last;
        bitmap     <= bitmap_base | masks;
        dup_flag   <= (first_beat ? 1'b0 : dup_flag) | beat_dup;
        range_flag <= (first_beat ? 1'b0 : range_flag) | beat_range;
      end
    end
  end

`ifdef ROUTE_CHECK_FIXED_START_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start_flag <= 1'b0;
    end else if (clear) begin
      start_flag <= 1'b0;
    end else if (s1_valid) begin
      start_flag <= (first_beat ? 1'b0 : start_flag) | beat_start;
    end
  end
`endif

  // Verdict stage; a full bitmap follows from no duplicates and no range errors
  logic fire;
  logic bad;
  logic range_out;

  assign fire = s2_valid && s2_last && !clear;

`ifdef ROUTE_CHECK_FIXED_START_EN
  assign range_out = range_flag | start_flag;
`else
  assign range_out = range_flag;
`endif

  assign bad = dup_flag | range_out;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done       <= 1'b0;
      ok         <= 1'b0;
      err_dup    <= 1'b0;
      err_range  <= 1'b0;
      pass_count <= '0;
      fail_count <= '0;
    end else begin
      done      <= fire;
      ok        <= fire && !bad;
      err_dup   <= fire && dup_flag;
      err_range <= fire && range_out;
      if (fire) begin
        if (bad) begin
          if (fail_count != 16'hFFFF) fail_count <= fail_count + 16'd1;
        end else begin
          if (pass_count != 16'hFFFF) pass_count <= pass_count + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_route_check.sv
// tb/tb_route_check.sv - scoreboard bench for route_check with a tour-level reference model
module tb_route_check;

  localparam int CN  = 48;
  localparam int CL  = 6;
  localparam int CD  = 6;
  localparam int CDL = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic [8*CL-1:0] in_data = '0;
  logic          done, ok, err_dup, err_range;
  logic [15:0]   pass_count, fail_count;

  route_check #(
    .CITY_NUM(CN), .CITY_NUM_LOG(CL), .CITY_DIV(CD), .CITY_DIV_LOG(CDL)
  ) dut (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .done(done), .ok(ok), .err_dup(err_dup), .err_range(err_range),
    .pass_count(pass_count), .fail_count(fail_count)
  );

  always #5 clk = ~clk;

  int         tour [CN];
  logic [2:0] expq [$];
  int         checks = 0;
  int         errors = 0;
  int         exp_pass = 0;
  int         exp_fail = 0;
  int         pushes = 0;
  int         dones = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Expected verdict {ok, dup, range} straight from the tour contents.
  function automatic logic [2:0] model();
    bit dup = 0;
    bit rng = 0;
    bit st  = 0;
    for (int i = 0; i < CN; i++) begin
      if (tour[i] >= CN) rng = 1;
      for (int j = i + 1; j < CN; j++)
        if (tour[i] == tour[j] && ((i / 8 == j / 8) || tour[i] < CN)) dup = 1;
    end
`ifdef ROUTE_CHECK_FIXED_START_EN
    st = (tour[0] != 0);
`endif
    return {!(dup | rng | st), dup, rng | st};
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      if (done) begin
        dones++;
        if (expq.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          logic [2:0] e;
          e = expq.pop_front();
          if (e[2]) exp_pass++; else exp_fail++;
          check("ok", ok, e[2]);
          check("err_dup", err_dup, e[1]);
          check("err_range", err_range, e[0]);
          check("pass_count", pass_count, exp_pass);
          check("fail_count", fail_count, exp_fail);
        end
      end else begin
        check("idle_flags", {ok, err_dup, err_range}, 0);
      end
    end
  end

  task automatic identity();
    for (int i = 0; i < CN; i++) tour[i] = i;
  endtask

  task automatic shuffle();
    identity();
    for (int i = CN - 1; i > 0; i--) begin
      int j, t;
      j = $urandom_range(0, i);
      t = tour[i]; tour[i] = tour[j]; tour[j] = t;
    end
  endtask

  task automatic send_tour(input int nbeats, input int gap, input bit clr_last, input bit push);
    if (push) begin
      expq.push_back(model());
      pushes++;
    end
    for (int b = 0; b < nbeats; b++) begin
      @(posedge clk); #1;
      clear    = clr_last && (b == nbeats - 1);
      in_valid = 1'b1;
      for (int k = 0; k < 8; k++) in_data[k*CL +: CL] = CL'(tour[b*8 + k]);
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        clear    = 1'b0;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      clear    = 1'b0;
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_done", done, 0);
    check("reset_flags", {ok, err_dup, err_range}, 0);
    check("reset_pass", pass_count, 0);
    check("reset_fail", fail_count, 0);
    reset = 1'b1;
    idle(2);

    identity(); send_tour(CD, 0, 0, 1);
    identity(); tour[4] = 3; send_tour(CD, 0, 0, 1);
    identity(); tour[2] = 9; tour[9] = 2; tour[35] = 9; send_tour(CD, 0, 0, 1);
    identity(); tour[13] = 50; send_tour(CD, 0, 0, 1);
    idle(4);

    for (int t = 0; t < 3; t++) begin
      shuffle(); tour[tour[0]] = tour[0]; identity();
      shuffle(); send_tour(CD, 0, 0, 1);
    end
    shuffle(); send_tour(CD, 5, 0, 1);
    idle(4);

    for (int t = 0; t < 40; t++) begin
      int mode, a, b;
      shuffle();
      mode = $urandom_range(0, 3);
      a = $urandom_range(0, CN - 1);
      b = (a + $urandom_range(1, CN - 1)) % CN;
      if (mode == 1 || mode == 3) tour[a] = tour[b];
      if (mode == 2 || mode == 3) tour[$urandom_range(0, CN - 1)] = $urandom_range(CN, 63);
      send_tour(CD, $urandom_range(0, 2), 0, 1);
    end
    idle(5);

    identity(); send_tour(1, 0, 0, 0);
    @(posedge clk); #1; in_valid = 1'b0; clear = 1'b1;
    identity(); send_tour(CD, 0, 0, 1);
    idle(5);

    shuffle(); send_tour(CD, 0, 1, 0);
    idle(5);

    shuffle(); send_tour(CD, 0, 0, 0);
    @(posedge clk); #1; in_valid = 1'b0; clear = 1'b1;
    idle(5);

    for (int i = 0; i < CN; i++) tour[i] = (i + 5) % CN;
    send_tour(CD, 0, 0, 1);
    idle(5);

    identity(); send_tour(3, 0, 0, 0);
    @(posedge clk); #1; in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("async_done", done, 0);
    check("async_flags", {ok, err_dup, err_range}, 0);
    check("async_pass", pass_count, 0);
    check("async_fail", fail_count, 0);
    exp_pass = 0;
    exp_fail = 0;
    @(posedge clk); #1; reset = 1'b1;
    identity(); send_tour(CD, 0, 0, 1);
    idle(2);

    for (int i = 0; i < 100 && expq.size() != 0; i++) @(posedge clk);
    idle(2);
    check("drain", expq.size(), 0);
    check("done_count", dones, pushes);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
